// File: rtl/aes_plaintext_loader.sv
// Byte-stream to 128-bit block loader for the AES-128 encrypt core, with key snapshot and 2-entry output buffer.
// Define AES_PAD_EN for PKCS#7 padding; otherwise partial blocks are zero-filled.
module aes_plaintext_loader #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_in,
  input  logic         key_load,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [127:0] plaintext,
  output logic [127:0] key,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic         blk_padded
);

  typedef enum logic {FILL, PAD} state_t;

  state_t       state;
  state_t       state_next;
  logic [127:0] key_reg;
  logic [127:0] asm_reg;
  logic [127:0] asm_next;
  logic [4:0]   k;
  logic [4:0]   k_next;
  logic [7:0]   fill_byte;
  logic         accept;
  logic         push;
  logic         push_padded;
  logic         pop;
  logic [1:0]   buf_count;
  logic [127:0] buf_data [2];
  logic [127:0] buf_key  [2];
  logic         buf_padded [2];

  // Bit offset of stream byte i inside the 128-bit block
  function automatic int slot_lsb(input int i);
    return MSB_FIRST ? (120 - 8 * i) : (8 * i);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FILL: begin
`ifdef AES_PAD_EN
        if (accept && in_last) state_next = PAD;
`else
        if (accept && in_last && (k != 5'd15)) state_next = PAD;
`endif
      end
      PAD: begin
        if (buf_count < 2'd2) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  always_comb begin
    in_ready    = (state == FILL) && (buf_count < 2'd2);
    accept      = in_valid && in_ready;
    blk_valid   = (buf_count != 2'd0);
    pop         = blk_valid && blk_ready;
`ifdef AES_PAD_EN
    fill_byte   = {3'b000, 5'd16 - k};
`else
    fill_byte   = 8'h00;
`endif
    asm_next    = asm_reg;
    k_next      = k;
    push        = 1'b0;
    push_padded = 1'b0;
    if (state == FILL) begin
      if (accept) begin
        for (int i = 0; i < 16; i++) begin
          if (k == 5'(i)) asm_next[slot_lsb(i) +: 8] = in_data;
        end
        if (k == 5'd15) begin
          push   = 1'b1;
          k_next = 5'd0;
        end else begin
          k_next = k + 5'd1;
        end
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (5'(i) >= k) asm_next[slot_lsb(i) +: 8] = fill_byte;
      end
      if (buf_count < 2'd2) begin
        push        = 1'b1;
        push_padded = 1'b1;
        k_next      = 5'd0;
      end
    end
  end

  // The snapshot pushed with a block is the key register value before this edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_reg <= '0;
      asm_reg <= '0;
      k       <= '0;
    end else begin
      if (key_load) key_reg <= key_in;
      asm_reg <= asm_next;
      k       <= k_next;
    end
  end

  // Entry 0 is always the head; a pop shifts entry 1 forward
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_count     <= '0;
      buf_data[0]   <= '0;
      buf_data[1]   <= '0;
      buf_key[0]    <= '0;
      buf_key[1]    <= '0;
      buf_padded[0] <= 1'b0;
      buf_padded[1] <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (buf_count == 2'd0) begin
            buf_data[0]   <= asm_next;
            buf_key[0]    <= key_reg;
            buf_padded[0] <= push_padded;
          end else begin
            buf_data[1]   <= asm_next;
            buf_key[1]    <= key_reg;
            buf_padded[1] <= push_padded;
          end
          buf_count <= buf_count + 2'd1;
        end
        2'b01: begin
          buf_data[0]   <= buf_data[1];
          buf_key[0]    <= buf_key[1];
          buf_padded[0] <= buf_padded[1];
          buf_count     <= buf_count - 2'd1;
        end
        2'b11: begin
          if (buf_count == 2'd1) begin
            buf_data[0]   <= asm_next;
            buf_key[0]    <= key_reg;
            buf_padded[0] <= push_padded;
          end else begin
            buf_data[0]   <= buf_data[1];
            buf_key[0]    <= buf_key[1];
            buf_padded[0] <= buf_padded[1];
            buf_data[1]   <= asm_next;
            buf_key[1]    <= key_reg;
            buf_padded[1] <= push_padded;
          end
        end
        default: ;
      endcase
    end
  end

  assign plaintext  = buf_data[0];
  assign key        = buf_key[0];
  assign blk_padded = blk_valid && buf_padded[0];

endmodule

// File: tb/tb_aes_plaintext_loader.sv
// Self-checking bench for aes_plaintext_loader: random byte streams against a block-level reference model.
// Honours AES_PAD_EN the same way as the design.
module tb_aes_plaintext_loader;

  localparam bit MSB_FIRST = 1'b1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] key_in;
  logic         key_load;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         blk_valid;
  logic         blk_ready;
  logic         blk_padded;

  typedef struct {
    logic [127:0] data;
    logic [127:0] key;
    logic         padded;
  } blk_t;

  blk_t         exp_q[$];
  logic [7:0]   cur_bytes[$];
  logic [127:0] model_key;
  blk_t         mon_e;
  int           checks   = 0;
  int           failures = 0;
  int           pops     = 0;
  bit           rand_done;

  aes_plaintext_loader #(.MSB_FIRST(MSB_FIRST)) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_load(key_load),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .plaintext(plaintext), .key(key), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_padded(blk_padded)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [127:0] pack_bytes(input logic [7:0] b[$]);
    logic [127:0] d = '0;
    for (int i = 0; i < 16; i++) begin
      if (MSB_FIRST) d = (d << 8) | 128'(b[i]);
      else           d = d | (128'(b[i]) << (8 * i));
    end
    return d;
  endfunction

  // Reference model: collect accepted bytes, emit full blocks and padded tails
  task automatic model_accept(input logic [7:0] b, input logic last);
    blk_t       e;
    logic [7:0] fill;
    cur_bytes.push_back(b);
    if (cur_bytes.size() == 16) begin
      e.data = pack_bytes(cur_bytes); e.key = model_key; e.padded = 1'b0;
      exp_q.push_back(e);
      cur_bytes.delete();
    end
    if (last) begin
      if (cur_bytes.size() != 0) begin
`ifdef AES_PAD_EN
        fill = 8'(16 - cur_bytes.size());
`else
        fill = 8'h00;
`endif
        while (cur_bytes.size() < 16) cur_bytes.push_back(fill);
        e.data = pack_bytes(cur_bytes); e.key = model_key; e.padded = 1'b1;
        exp_q.push_back(e);
        cur_bytes.delete();
      end else begin
`ifdef AES_PAD_EN
        e.data = {16{8'h10}}; e.key = model_key; e.padded = 1'b1;
        exp_q.push_back(e);
`endif
      end
    end
  endtask

  // Scoreboard: every block the consumer takes must match the model's next block
  always @(negedge clk) begin
    #1;
    if (blk_valid && blk_ready) begin
      checks++;
      pops++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL pop_unexpected: got data=%h, required no block", plaintext);
      end else begin
        mon_e = exp_q.pop_front();
        if (plaintext !== mon_e.data || key !== mon_e.key || blk_padded !== mon_e.padded) begin
          failures++;
          $display("[TB] FAIL pop_block: got data=%h key=%h padded=%b, required data=%h key=%h padded=%b",
                   plaintext, key, blk_padded, mon_e.data, mon_e.key, mon_e.padded);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic last);
    int g = 0;
    in_data = b; in_valid = 1'b1; in_last = last;
    while (!in_ready && g < 500) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("[TB] FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, g);
      in_valid = 1'b0; in_last = 1'b0;
      return;
    end
    @(posedge clk);
    model_accept(b, last);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic load_key(input logic [127:0] kv);
    int g = 0;
    while (!in_ready && g < 500) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("[TB] FAIL key_timeout: in_ready=%b, required 1", in_ready);
    end
    key_in = kv; key_load = 1'b1;
    @(posedge clk);
    model_key = kv;
    @(negedge clk);
    key_load = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    blk_ready = 1'b1;
    while (exp_q.size() != 0 && g < 500) begin
      @(negedge clk);
      g++;
    end
    blk_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || blk_valid !== 1'b0 || blk_padded !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: got in_ready=%b blk_valid=%b blk_padded=%b, required 1 0 0", in_ready, blk_valid, blk_padded);
    end
    checks++;
    if (plaintext !== '0 || key !== '0) begin
      failures++;
      $display("[TB] FAIL reset_data: got plaintext=%h key=%h, required zero", plaintext, key);
    end
    @(negedge clk);
    load_key({$urandom, $urandom, $urandom, $urandom});
    blk_ready = 1'b0;
    for (int i = 0; i < 19; i++) send_byte(8'($urandom), 1'b0);
    checks++;
    if (blk_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_prefill: got blk_valid=%b, required 1", blk_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (blk_valid !== 1'b0 || plaintext !== '0 || key !== '0 || blk_padded !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid: got blk_valid=%b plaintext=%h key=%h padded=%b, required all zero",
               blk_valid, plaintext, key, blk_padded);
    end
    exp_q.delete();
    cur_bytes.delete();
    model_key = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_release: got in_ready=%b, required 1", in_ready);
    end
    @(negedge clk);
    for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'b0);
    drain();
    checks++;
    if (exp_q.size() != 0 || blk_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_drain: got %0d pending blk_valid=%b, required 0 0", exp_q.size(), blk_valid);
    end
  endtask

  task automatic test_known_vector();
    load_key(128'h000102030405060708090a0b0c0d0e0f);
    blk_ready = 1'b0;
    for (int i = 0; i < 15; i++) send_byte(8'(i * 17), 1'b0);
    checks++;
    if (blk_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL kv_early_valid: got blk_valid=%b, required 0", blk_valid);
    end
    send_byte(8'hff, 1'b0);
    checks++;
    if (blk_valid !== 1'b1 || blk_padded !== 1'b0) begin
      failures++;
      $display("[TB] FAIL kv_valid: got blk_valid=%b blk_padded=%b, required 1 0", blk_valid, blk_padded);
    end
    checks++;
    if (plaintext !== 128'h00112233445566778899aabbccddeeff) begin
      failures++;
      $display("[TB] FAIL kv_plaintext: got %h, required 00112233445566778899aabbccddeeff", plaintext);
    end
    checks++;
    if (key !== 128'h000102030405060708090a0b0c0d0e0f) begin
      failures++;
      $display("[TB] FAIL kv_key: got %h, required 000102030405060708090a0b0c0d0e0f", key);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [7:0] d[48];
    int         p0 = pops;
    foreach (d[i]) d[i] = 8'($urandom);
    blk_ready = 1'b0;
    for (int i = 0; i < 32; i++) send_byte(d[i], 1'b0);
    checks++;
    if (in_ready !== 1'b0 || blk_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_full: got in_ready=%b blk_valid=%b, required 0 1", in_ready, blk_valid);
    end
    in_data = d[32]; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || blk_valid !== 1'b1) begin
        failures++;
        $display("[TB] FAIL bp_stall: got in_ready=%b blk_valid=%b, required 0 1", in_ready, blk_valid);
      end
    end
    in_valid = 1'b0;
    blk_ready = 1'b1;
    @(negedge clk);
    blk_ready = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || blk_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_release: got in_ready=%b blk_valid=%b, required 1 1", in_ready, blk_valid);
    end
    @(negedge clk);
    for (int i = 32; i < 48; i++) send_byte(d[i], 1'b0);
    drain();
    checks++;
    if (pops - p0 != 3 || exp_q.size() != 0 || blk_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_count: got %0d blocks (%0d pending), required 3 (0 pending)", pops - p0, exp_q.size());
    end
  endtask

  task automatic test_partial_pad();
    logic [127:0] exp_data;
`ifdef AES_PAD_EN
    exp_data = {40'h0102030405, {11{8'h0b}}};
`else
    exp_data = {40'h0102030405, 88'h0};
`endif
    blk_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send_byte(8'(i), i == 5);
    checks++;
    if (in_ready !== 1'b0 || blk_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL pad_state: got in_ready=%b blk_valid=%b, required 0 0", in_ready, blk_valid);
    end
    @(negedge clk);
    checks++;
    if (blk_valid !== 1'b1 || blk_padded !== 1'b1 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL pad_commit: got blk_valid=%b blk_padded=%b in_ready=%b, required 1 1 1", blk_valid, blk_padded, in_ready);
    end
    checks++;
    if (plaintext !== exp_data) begin
      failures++;
      $display("[TB] FAIL pad_data: got %h, required %h", plaintext, exp_data);
    end
    drain();
  endtask

  task automatic test_full_last();
    int p0 = pops;
    int exp_blocks;
`ifdef AES_PAD_EN
    exp_blocks = 2;
`else
    exp_blocks = 1;
`endif
    blk_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(8'($urandom), i == 15);
    checks++;
    if (blk_valid !== 1'b1 || blk_padded !== 1'b0) begin
      failures++;
      $display("[TB] FAIL last16_head: got blk_valid=%b blk_padded=%b, required 1 0", blk_valid, blk_padded);
    end
    drain();
    checks++;
    if (pops - p0 != exp_blocks || exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL last16_count: got %0d blocks, required %0d", pops - p0, exp_blocks);
    end
  endtask

  task automatic test_key_switch();
    logic [127:0] ka = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] kb = ~ka;
    load_key(ka);
    blk_ready = 1'b0;
    for (int i = 0; i < 15; i++) send_byte(8'($urandom), 1'b0);
    key_in = kb; key_load = 1'b1;
    send_byte(8'($urandom), 1'b0);
    key_load = 1'b0;
    model_key = kb;
    checks++;
    if (key !== ka) begin
      failures++;
      $display("[TB] FAIL key_snapshot: got %h, required %h", key, ka);
    end
    for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'b0);
    drain();
    checks++;
    if (exp_q.size() != 0 || blk_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL key_drain: got %0d pending blk_valid=%b, required 0 0", exp_q.size(), blk_valid);
    end
  endtask

  task automatic test_random();
    rand_done = 1'b0;
    fork
      begin
        for (int m = 0; m < 8; m++) begin
          int len = $urandom_range(1, 40);
          if ($urandom % 2) load_key({$urandom, $urandom, $urandom, $urandom});
          for (int j = 0; j < len; j++) begin
            send_byte(8'($urandom), j == len - 1);
            if ($urandom % 4 == 0) @(negedge clk);
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(negedge clk);
          blk_ready = 1'($urandom % 2);
        end
      end
    join
    drain();
    checks++;
    if (exp_q.size() != 0 || blk_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL random_drain: got %0d pending blk_valid=%b, required 0 0", exp_q.size(), blk_valid);
    end
  endtask

  initial begin
    rst_n = 1'b0; key_in = '0; key_load = 1'b0;
    in_data = '0; in_valid = 1'b0; in_last = 1'b0; blk_ready = 1'b0;
    model_key = '0;
    test_reset();
    test_known_vector();
    test_backpressure();
    test_partial_pad();
    test_full_last();
    test_key_switch();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
